psa_mode_sel: RTL and testbench

PSA_MODE_SEL -- requirements
Module: psa_mode_sel

---
 rtl/psa_mode_sel.sv | 147 ++++++++++++++
 tb/tb_psa_mode_sel.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psa_mode_sel.sv
// psa_mode_sel: debounces the slot reset, stretches its release and advances a mode on every release.
// Optional macro PSA_MODE_DIPSW_LOCK_EN lets i_DIPSW[3] pin the mode to i_DIPSW (saturated).
module psa_mode_sel #(
    parameter int MODES    = 3,
    parameter int MODE_W   = 2,
    parameter int DEBOUNCE = 4,
    parameter int STRETCH  = 8
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_SYS_nRST,
    input  logic [3:0]        i_DIPSW,
    output logic [MODE_W-1:0] o_MODE,
    output logic [MODE_W-1:0] o_nLED,
    output logic              o_SYS_RST,
    output logic              o_ADVANCE
);

    typedef enum logic [1:0] {
        PON,
        RUN,
        SYS_RST,
        RELEASE
    } psaState;

    localparam logic [MODE_W-1:0] LAST_MODE   = MODE_W'(MODES - 1);
    localparam logic [MODE_W-1:0] ONE_MODE    = MODE_W'(1);
    localparam logic [7:0]        DEB_LAST    = 8'(DEBOUNCE - 1);
    localparam logic [7:0]        STRETCH_END = 8'(STRETCH);

    psaState           state;
    psaState           nextState;
    logic              syncMeta;
    logic              syncLevel;
    logic [7:0]        debCount;
    logic              acceptedLevel;
    logic [7:0]        stretchCount;
    logic              advanceNow;
    logic              locked;
    logic [MODE_W-1:0] lockMode;
    logic [MODE_W-1:0] mode;
    logic              advancePulse;
    logic              unusedDip;

    // The synchroniser clears to the low (reset asserted) level.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            syncMeta  <= 1'b0;
            syncLevel <= 1'b0;
        end else begin
            syncMeta  <= i_SYS_nRST;
            syncLevel <= syncMeta;
        end
    end

    // A new level is taken only after DEBOUNCE consecutive samples that differ from the accepted one.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            debCount      <= 8'd0;
            acceptedLevel <= 1'b0;
        end else if (syncLevel == acceptedLevel) begin
            debCount <= 8'd0;
        end else if (debCount == DEB_LAST) begin
            debCount      <= 8'd0;
            acceptedLevel <= syncLevel;
        end else begin
            debCount <= debCount + 8'd1;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state <= PON;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            PON:     if (acceptedLevel) nextState = RELEASE;
            RUN:     if (!acceptedLevel) nextState = SYS_RST;
            SYS_RST: if (acceptedLevel) nextState = RELEASE;
            RELEASE: begin
                if (!acceptedLevel) begin
                    nextState = SYS_RST;
                end else if (stretchCount == STRETCH_END) begin
                    nextState = RUN;
                end
            end
            default: nextState = PON;
        endcase
    end

    always_comb begin
        o_SYS_RST  = (state != RUN);
        advanceNow = (state == SYS_RST) && acceptedLevel && !locked;
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            stretchCount <= 8'd0;
        end else if ((state == RELEASE) && (nextState == RELEASE)) begin
            stretchCount <= stretchCount + 8'd1;
        end else begin
            stretchCount <= 8'd0;
        end
    end

`ifdef PSA_MODE_DIPSW_LOCK_EN
    logic [MODE_W-1:0] dipMode;

    always_comb begin
        locked   = i_DIPSW[3];
        dipMode  = MODE_W'(i_DIPSW);
        lockMode = (dipMode > LAST_MODE) ? LAST_MODE : dipMode;
    end
`else
    always_comb begin
        locked   = 1'b0;
        lockMode = '0;
    end
`endif

    assign unusedDip = ^i_DIPSW;

    // The mode moves only on a non-first release (or follows the switches while locked).
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            mode         <= '0;
            advancePulse <= 1'b0;
        end else begin
            advancePulse <= advanceNow;
            if (locked) begin
                mode <= lockMode;
            end else if (advanceNow) begin
                mode <= (mode == LAST_MODE) ? '0 : mode + ONE_MODE;
            end
        end
    end

    assign o_MODE    = mode;
    assign o_nLED    = ~mode;
    assign o_ADVANCE = advancePulse;

endmodule

// File: tb/tb_psa_mode_sel.sv
// tb_psa_mode_sel: random and directed slot-reset traffic against two DUTs (3 and 4 modes)
// compared each cycle with a behavioural model of debounce, stretch and mode advance.
module tb_psa_mode_sel;

    localparam int DEBOUNCE = 4;
    localparam int STRETCH  = 8;
    localparam int HIST     = 32;
`ifdef PSA_MODE_DIPSW_LOCK_EN
    localparam bit LOCK_BUILD = 1'b1;
`else
    localparam bit LOCK_BUILD = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       sysNrst;
    logic [3:0] dipSw;
    logic [1:0] mode3, nled3, mode4, nled4;
    logic       sysRst3, adv3, sysRst4, adv4;

    int errors = 0;
    int checks = 0;

    bit inHist [HIST];
    bit accHist[HIST];
    bit accLevel;
    int riseCount;
    bit pendingAdv;
    int expMode3, expMode4;
    bit expAdv, expSysRst;

    int dutAdvCount  = 0;
    int dutRstRises  = 0;
    int dutRstFalls  = 0;
    bit prevSysRst   = 1'b1;

    psa_mode_sel #(.MODES(3), .MODE_W(2), .DEBOUNCE(DEBOUNCE), .STRETCH(STRETCH)) dut3 (
        .i_CLK(clock), .i_RST(reset), .i_SYS_nRST(sysNrst), .i_DIPSW(dipSw),
        .o_MODE(mode3), .o_nLED(nled3), .o_SYS_RST(sysRst3), .o_ADVANCE(adv3)
    );

    psa_mode_sel #(.MODES(4), .MODE_W(2), .DEBOUNCE(DEBOUNCE), .STRETCH(STRETCH)) dut4 (
        .i_CLK(clock), .i_RST(reset), .i_SYS_nRST(sysNrst), .i_DIPSW(dipSw),
        .o_MODE(mode4), .o_nLED(nled4), .o_SYS_RST(sysRst4), .o_ADVANCE(adv4)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit level, input int cycles);
        sysNrst = level;
        repeat (cycles) @(negedge clock);
    endtask

    // Every accepted rise of the debounced level except the first after reset advances the mode
    // one edge later; the internal reset drops once the level has been accepted high for STRETCH+2 edges.
    task automatic modelStep(input bit r, input bit inNow, input bit [3:0] dipNow);
        bit allDiffer;
        bit running;
        bit isLocked;
        int dv;
        if (r) begin
            for (int k = 0; k < HIST; k++) begin
                inHist[k]  = 1'b0;
                accHist[k] = 1'b0;
            end
            accLevel   = 1'b0;
            riseCount  = 0;
            pendingAdv = 1'b0;
            expMode3   = 0;
            expMode4   = 0;
            expAdv     = 1'b0;
            expSysRst  = 1'b1;
            return;
        end
        isLocked = LOCK_BUILD && dipNow[3];
        dv = int'(dipNow[1:0]);
        if (isLocked) begin
            expMode3 = (dv > 2) ? 2 : dv;
            expMode4 = dv;
            expAdv   = 1'b0;
        end else if (pendingAdv) begin
            expMode3 = (expMode3 + 1) % 3;
            expMode4 = (expMode4 + 1) % 4;
            expAdv   = 1'b1;
        end else begin
            expAdv = 1'b0;
        end
        pendingAdv = 1'b0;

        allDiffer = 1'b1;
        for (int k = 1; k <= DEBOUNCE; k++) begin
            if (inHist[k] == accLevel) allDiffer = 1'b0;
        end
        if (allDiffer) begin
            accLevel = !accLevel;
            if (accLevel) begin
                riseCount++;
                pendingAdv = (riseCount > 1);
            end
        end

        for (int k = HIST - 1; k > 0; k--) accHist[k] = accHist[k-1];
        accHist[0] = accLevel;
        running = 1'b1;
        for (int k = 1; k <= STRETCH + 2; k++) begin
            if (!accHist[k]) running = 1'b0;
        end
        expSysRst = !running;

        for (int k = HIST - 1; k > 0; k--) inHist[k] = inHist[k-1];
        inHist[0] = inNow;
    endtask

    initial begin
        bit sampRst, sampIn;
        bit [3:0] sampDip;
        forever begin
            @(posedge clock);
            sampRst = reset;
            sampIn  = sysNrst;
            sampDip = dipSw;
            #1;
            modelStep(sampRst, sampIn, sampDip);
            checkOutput("mode3", int'(mode3), expMode3);
            checkOutput("nled3", int'(nled3), 3 - expMode3);
            checkOutput("sysRst3", int'(sysRst3), int'(expSysRst));
            checkOutput("adv3", int'(adv3), int'(expAdv));
            checkOutput("mode4", int'(mode4), expMode4);
            checkOutput("nled4", int'(nled4), 3 - expMode4);
            checkOutput("sysRst4", int'(sysRst4), int'(expSysRst));
            checkOutput("adv4", int'(adv4), int'(expAdv));
            if (adv3) dutAdvCount++;
            if (prevSysRst && !sysRst3) dutRstFalls++;
            if (!prevSysRst && sysRst3) dutRstRises++;
            prevSysRst = sysRst3;
        end
    end

    initial begin
        int latency;
        int rises0, falls0, adv0;
        int exp3[4];
        int exp4[4];
        exp3 = '{1, 2, 0, 1};
        exp4 = '{1, 2, 3, 0};

        reset   = 1'b1;
        sysNrst = 1'b0;
        dipSw   = 4'b0000;
        repeat (3) @(negedge clock);
        checkOutput("resetMode", int'(mode3), 0);
        checkOutput("resetLed", int'(nled3), 3);
        checkOutput("resetSysRst", int'(sysRst3), 1);
        checkOutput("resetAdv", int'(adv3), 0);

        // First release after power-on: no advance, reset drops after the stretch.
        reset = 1'b0;
        applyStimulus(1'b0, 10);
        sysNrst = 1'b1;
        latency = 60;
        for (int j = 1; j <= 60; j++) begin
            @(posedge clock);
            #2;
            if (!sysRst3) begin
                latency = j - 1;
                break;
            end
        end
        @(negedge clock);
        checkOutput("releaseLatency", latency, 2 + DEBOUNCE + STRETCH + 1);
        applyStimulus(1'b1, 10);
        checkOutput("firstReleaseLed", int'(nled3), 3);
        checkOutput("firstReleaseAdv", dutAdvCount, 0);
        checkOutput("firstReleaseRun", int'(sysRst3), 0);

        for (int p = 0; p < 4; p++) begin
            applyStimulus(1'b0, 20);
            applyStimulus(1'b1, 30);
            checkOutput("pulseMode3", int'(mode3), exp3[p]);
            checkOutput("pulseLed3", int'(nled3), 3 - exp3[p]);
            checkOutput("pulseMode4", int'(mode4), exp4[p]);
        end
        checkOutput("pulseAdvCount", dutAdvCount, 4);

        // A 2-cycle glitch in RUN is shorter than the debounce window.
        rises0 = dutRstRises;
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 20);
        checkOutput("glitchRises", dutRstRises - rises0, 0);
        checkOutput("glitchMode", int'(mode3), 1);

        // Re-assert while the release is still being stretched.
        rises0 = dutRstRises;
        falls0 = dutRstFalls;
        adv0   = dutAdvCount;
        applyStimulus(1'b0, 20);
        applyStimulus(1'b1, 6);
        applyStimulus(1'b0, 20);
        applyStimulus(1'b1, 30);
        checkOutput("reassertRises", dutRstRises - rises0, 1);
        checkOutput("reassertFalls", dutRstFalls - falls0, 1);
        checkOutput("reassertAdv", dutAdvCount - adv0, 2);
        checkOutput("reassertMode3", int'(mode3), 0);
        checkOutput("reassertMode4", int'(mode4), 2);

`ifdef PSA_MODE_DIPSW_LOCK_EN
        dipSw = 4'b1011;
        adv0  = dutAdvCount;
        applyStimulus(1'b1, 2);
        checkOutput("lockMode3", int'(mode3), 2);
        checkOutput("lockMode4", int'(mode4), 3);
        for (int p = 0; p < 2; p++) begin
            applyStimulus(1'b0, 20);
            applyStimulus(1'b1, 30);
        end
        checkOutput("lockHeldMode3", int'(mode3), 2);
        checkOutput("lockAdv", dutAdvCount - adv0, 0);
        dipSw = 4'b0000;
        applyStimulus(1'b0, 20);
        applyStimulus(1'b1, 30);
        checkOutput("unlockMode3", int'(mode3), 0);
        checkOutput("unlockMode4", int'(mode4), 0);
        checkOutput("unlockAdv", dutAdvCount - adv0, 1);
`endif

        for (int s = 0; s < 300; s++) begin
            dipSw = 4'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clock);
                reset = 1'b0;
            end else begin
                applyStimulus(1'($urandom), $urandom_range(1, 25));
            end
        end
        dipSw = 4'b0000;
        applyStimulus(1'b1, 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
